// File: rtl/width_8to16_arbiter_if.sv
// Byte-requester and 16-bit word handshake bundle for width_8to16_arbiter.
// slave is the arbiter side, master is the producers/consumer side.
interface width_8to16_arbiter_if #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned SRC_W   = 2
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 out_valid;
  logic [15:0]          out_data;
  logic [SRC_W-1:0]     out_src;
  logic                 out_ready;
  logic                 busy;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_src, busy
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_src, busy
  );
endinterface

// File: rtl/width_8to16_arbiter.sv
// Round-robin arbiter sharing one 8-to-16 packer between NUM_REQ byte streams.
// The grant is locked for a whole byte pair so words never mix sources.
module width_8to16_arbiter #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned SRC_W   = 2
) (
  input logic                  clk,
  input logic                  rst,
  width_8to16_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StHi, StLo} state_e;

  state_e           state_q;
  logic [SRC_W-1:0] grant_q;
  logic [SRC_W-1:0] rr_ptr_q;
  logic [7:0]       hold_q;

  logic [SRC_W-1:0] pick, pick_hi, pick_lo;
  logic             found_hi, found_lo;
  logic [7:0]       cur_byte;
  logic             room;
  logic             xfer;

  // Lowest valid index at or above rr_ptr wins, else wrap to the lowest valid index.
  always_comb begin
    pick_hi  = '0;
    pick_lo  = '0;
    found_hi = 1'b0;
    found_lo = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.req_valid[i]) begin
        if (!found_lo) begin
          pick_lo  = SRC_W'(i);
          found_lo = 1'b1;
        end
        if (!found_hi && (SRC_W'(i) >= rr_ptr_q)) begin
          pick_hi  = SRC_W'(i);
          found_hi = 1'b1;
        end
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end

  assign room = !bus.out_valid || bus.out_ready;

  always_comb begin
    cur_byte      = 8'h00;
    bus.req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == SRC_W'(i)) begin
        cur_byte         = bus.req_data[8*i +: 8];
        bus.req_ready[i] = (state_q == StHi) || ((state_q == StLo) && room);
      end
    end
  end

  // req_ready is only ever set for the granted requester.
  assign xfer     = |(bus.req_valid & bus.req_ready);
  assign bus.busy = (state_q != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      grant_q       <= '0;
      rr_ptr_q      <= '0;
      hold_q        <= 8'h00;
      bus.out_valid <= 1'b0;
      bus.out_data  <= 16'h0000;
      bus.out_src   <= '0;
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          if (|bus.req_valid) begin
            grant_q <= pick;
            state_q <= StHi;
          end
        end
        StHi: begin
          if (xfer) begin
            hold_q  <= cur_byte;
            state_q <= StLo;
          end
        end
        StLo: begin
          // Load overrides the drain above, so a back-to-back word keeps out_valid high.
          if (xfer) begin
            bus.out_data  <= {hold_q, cur_byte};
            bus.out_src   <= grant_q;
            bus.out_valid <= 1'b1;
            rr_ptr_q      <= (grant_q == SRC_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            state_q       <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_width_8to16_arbiter.sv
// Directed bench for width_8to16_arbiter: a cycle table for a single pair plus
// queue-driven sequences for contention, backpressure, stalls, reset and wrap-around.
module tb_width_8to16_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst4 = 1'b1;
  always #5 clk = ~clk;

  width_8to16_arbiter_if #(.NUM_REQ(2), .SRC_W(2)) if2 ();
  width_8to16_arbiter_if #(.NUM_REQ(4), .SRC_W(2)) if4 ();

  width_8to16_arbiter #(.NUM_REQ(2), .SRC_W(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  width_8to16_arbiter #(.NUM_REQ(4), .SRC_W(2)) dut4 (.clk(clk), .rst(rst4), .bus(if4));

  int total = 0;
  int bad = 0;

  // Stimulus sources for the 2-requester DUT: table mode or queue-driver mode.
  logic        drv_en = 1'b0;
  logic [1:0]  tv_vld = 2'b00;
  logic [15:0] tv_dat = 16'h0000;
  logic [1:0]  dv_vld = 2'b00;
  logic [15:0] dv_dat = 16'h0000;
  logic        ordy2  = 1'b1;
  logic [7:0]  q0[$];
  logic [7:0]  q1[$];
  logic [17:0] got[$];
  logic [17:0] expw[$];

  assign if2.req_valid = drv_en ? dv_vld : tv_vld;
  assign if2.req_data  = drv_en ? dv_dat : tv_dat;
  assign if2.out_ready = ordy2;

  logic [3:0]  vld4  = 4'h0;
  logic        ordy4 = 1'b0;
  logic [17:0] got4[$];

  assign if4.req_valid = vld4;
  assign if4.req_data  = 32'hC3C2C1C0;
  assign if4.out_ready = ordy4;

  // Queue driver: pops on a seen handshake, presents the next byte after the edge.
  initial begin
    logic [1:0] fire;
    forever begin
      @(negedge clk);
      fire = if2.req_valid & if2.req_ready & {2{!rst}};
      @(posedge clk);
      #1;
      if (drv_en) begin
        if (fire[0] && q0.size() != 0) void'(q0.pop_front());
        if (fire[1] && q1.size() != 0) void'(q1.pop_front());
      end
      dv_vld[0]     = (q0.size() != 0);
      dv_vld[1]     = (q1.size() != 0);
      dv_dat[7:0]   = (q0.size() != 0) ? q0[0] : 8'h00;
      dv_dat[15:8]  = (q1.size() != 0) ? q1[0] : 8'h00;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && if2.out_valid && if2.out_ready) got.push_back({if2.out_src, if2.out_data});
      if (!rst4 && if4.out_valid && if4.out_ready) got4.push_back({if4.out_src, if4.out_data});
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_words(input int n);
    int cyc = 0;
    while (got.size() < n && cyc < 200) begin
      @(posedge clk);
      cyc++;
    end
  endtask

  task automatic check_words(input string name);
    check({name, " count"}, got.size(), expw.size());
    for (int i = 0; i < expw.size() && i < got.size(); i++) begin
      check($sformatf("%s word%0d", name, i), {14'd0, got[i]}, {14'd0, expw[i]});
    end
  endtask

  typedef struct {
    logic [1:0]  vld;
    logic [7:0]  d0;
    logic [1:0]  x_rdy;
    logic        x_ov;
    logic [15:0] x_od;
    logic [1:0]  x_src;
    logic        x_busy;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{2'b01, 8'hA5, 2'b00, 1'b0, 16'h0000, 2'd0, 1'b0};
    vecs[1] = '{2'b01, 8'hA5, 2'b01, 1'b0, 16'h0000, 2'd0, 1'b1};
    vecs[2] = '{2'b01, 8'h3C, 2'b01, 1'b0, 16'h0000, 2'd0, 1'b1};
    vecs[3] = '{2'b00, 8'h00, 2'b00, 1'b1, 16'hA53C, 2'd0, 1'b0};
    vecs[4] = '{2'b00, 8'h00, 2'b00, 1'b0, 16'hA53C, 2'd0, 1'b0};

    apply_reset();
    @(negedge clk);
    check("rst out_valid", if2.out_valid, 1'b0);
    check("rst out_data", if2.out_data, 16'h0000);
    check("rst out_src", if2.out_src, 2'd0);
    check("rst busy", if2.busy, 1'b0);
    check("rst req_ready", if2.req_ready, 2'b00);
    @(posedge clk);
    #1;

    // Single requester, cycle by cycle.
    for (int i = 0; i < 5; i++) begin
      tv_vld = vecs[i].vld;
      tv_dat = {8'h00, vecs[i].d0};
      @(negedge clk);
      check($sformatf("single c%0d req_ready", i), if2.req_ready, vecs[i].x_rdy);
      check($sformatf("single c%0d out_valid", i), if2.out_valid, vecs[i].x_ov);
      check($sformatf("single c%0d out_data", i), if2.out_data, vecs[i].x_od);
      check($sformatf("single c%0d out_src", i), if2.out_src, vecs[i].x_src);
      check($sformatf("single c%0d busy", i), if2.busy, vecs[i].x_busy);
      @(posedge clk);
      #1;
    end

    // Contention: pairs alternate between the two requesters.
    apply_reset();
    drv_en = 1'b1;
    got.delete();
    q0 = '{8'h11, 8'h22, 8'h33, 8'h44};
    q1 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    wait_words(4);
    expw = '{{2'd0, 16'h1122}, {2'd1, 16'hAABB}, {2'd0, 16'h3344}, {2'd1, 16'hCCDD}};
    check_words("contention");

    // Backpressure: first word held, second pair stalls in LO, then drain+load.
    apply_reset();
    got.delete();
    ordy2 = 1'b0;
    q0 = '{8'h12, 8'h34, 8'h56, 8'h78};
    for (int c = 0; c < 30 && !if2.out_valid; c++) @(negedge clk);
    repeat (6) @(negedge clk);
    check("bp held out_valid", if2.out_valid, 1'b1);
    check("bp held out_data", if2.out_data, 16'h1234);
    check("bp held out_src", if2.out_src, 2'd0);
    check("bp stall req_ready", if2.req_ready, 2'b00);
    check("bp stall busy", if2.busy, 1'b1);
    @(posedge clk);
    #1;
    ordy2 = 1'b1;
    @(negedge clk);
    check("bp release req_ready", if2.req_ready, 2'b01);
    @(negedge clk);
    check("bp no bubble out_valid", if2.out_valid, 1'b1);
    check("bp second out_data", if2.out_data, 16'h5678);
    wait_words(2);
    expw = '{{2'd0, 16'h1234}, {2'd0, 16'h5678}};
    check_words("backpressure");

    // Mid-pair stall: req1 locked in LO while req0 waits.
    apply_reset();
    got.delete();
    q1.push_back(8'h5A);
    for (int c = 0; c < 30 && q1.size() != 0; c++) @(negedge clk);
    q0.push_back(8'hE1);
    q0.push_back(8'hE2);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("stall c%0d req_ready", c), if2.req_ready, 2'b10);
      check($sformatf("stall c%0d busy", c), if2.busy, 1'b1);
    end
    q1.push_back(8'hC3);
    wait_words(2);
    expw = '{{2'd1, 16'h5AC3}, {2'd0, 16'hE1E2}};
    check_words("midstall");

    // Reset in LO: pair discarded and rr_ptr back to 0 (so req0 wins next).
    got.delete();
    q0.push_back(8'h77);
    for (int c = 0; c < 30 && q0.size() != 0; c++) @(negedge clk);
    check("rstmid busy before", if2.busy, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstmid busy after", if2.busy, 1'b0);
    check("rstmid out_valid after", if2.out_valid, 1'b0);
    q0 = '{8'h01, 8'h02};
    q1 = '{8'hF1, 8'hF2};
    wait_words(2);
    expw = '{{2'd0, 16'h0102}, {2'd1, 16'hF1F2}};
    check_words("rstmid");

    // Wrap-around on the 4-requester instance.
    vld4  = 4'hF;
    ordy4 = 1'b1;
    @(posedge clk);
    #1;
    rst4 = 1'b0;
    for (int c = 0; c < 200 && got4.size() < 8; c++) @(posedge clk);
    vld4 = 4'h0;
    check("wrap count", (got4.size() >= 8) ? 32'd1 : 32'd0, 32'd1);
    for (int k = 0; k < 8 && k < got4.size(); k++) begin
      logic [7:0] b;
      b = 8'hC0 + 8'(k % 4);
      check($sformatf("wrap word%0d", k), {14'd0, got4[k]}, {14'd0, 2'(k % 4), b, b});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
